// File: rtl/multi_period_mul_acc.sv
// Sine/cosine correlator: multiplies ADC samples by SIN/COS references, accumulates per
// half-period (split at zero crossings) and reports sums over the last 2^PERIODS_LOG2 half-periods.
// Optional macro MUL_ACC_HYSTERESIS_EN enables ZC_HYST hysteresis on crossing detection.
module multi_period_mul_acc #(
    parameter int SIN_TABLE_DATA_WIDTH = 13,
    parameter int ADC_DATA_WIDTH       = 12,
    parameter int RESULT_WIDTH         = 36,
    parameter int PERIODS_LOG2         = 2,
    parameter int PERIOD_WIDTH         = 16,
    parameter int ZC_HYST              = 16
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   CE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
    input  logic signed [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
    output logic                                   UPDATED_RESULT,
    output logic signed [RESULT_WIDTH-1:0]         SIN_RESULT,
    output logic signed [RESULT_WIDTH-1:0]         COS_RESULT,
    output logic        [PERIOD_WIDTH-1:0]         LAST_LEN
);
    localparam int PW = SIN_TABLE_DATA_WIDTH + ADC_DATA_WIDTH;
    localparam int N  = 1 << PERIODS_LOG2;

    logic                                   r_sign_neg;
    logic [1:0]                             r_vld_pipe;
    logic signed [SIN_TABLE_DATA_WIDTH-1:0] r_sin0, r_cos0;
    logic signed [ADC_DATA_WIDTH-1:0]       r_adc0;
    logic                                   r_cross0, r_cross1;
    logic signed [RESULT_WIDTH-1:0]         r_prod_sin, r_prod_cos;
    logic signed [RESULT_WIDTH-1:0]         r_acc_sin, r_acc_cos, r_fin_sin, r_fin_cos;
    logic [PERIOD_WIDTH-1:0]                r_len, r_fin_len, r_last_len;
    logic                                   r_hand, r_upd;
    logic signed [RESULT_WIDTH-1:0]         r_hist_sin [N];
    logic signed [RESULT_WIDTH-1:0]         r_hist_cos [N];
    logic signed [RESULT_WIDTH-1:0]         r_win_sin, r_win_cos;
    logic [PERIODS_LOG2-1:0]                r_wptr;
    logic [PERIODS_LOG2:0]                  r_fill;

    logic                                   w_cross;
    logic signed [PW-1:0]                   w_prod_sin, w_prod_cos;

`ifdef MUL_ACC_HYSTERESIS_EN
    always_comb w_cross = r_sign_neg ? (int'(ADC_VALUE) > ZC_HYST) : (int'(ADC_VALUE) < -ZC_HYST);
`else
    always_comb w_cross = ADC_VALUE[ADC_DATA_WIDTH-1] != r_sign_neg;
`endif

    always_comb begin
        w_prod_sin = PW'(r_sin0) * PW'(r_adc0);
        w_prod_cos = PW'(r_cos0) * PW'(r_adc0);
    end

    // Stage0/1: register inputs with crossing flag, then the products.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sign_neg <= 1'b0;
            r_vld_pipe <= '0;
            r_sin0     <= '0;
            r_cos0     <= '0;
            r_adc0     <= '0;
            r_cross0   <= 1'b0;
            r_cross1   <= 1'b0;
            r_prod_sin <= '0;
            r_prod_cos <= '0;
        end else if (CE) begin
            r_vld_pipe <= {r_vld_pipe[0], 1'b1};
            r_sin0     <= SIN_VALUE;
            r_cos0     <= COS_VALUE;
            r_adc0     <= ADC_VALUE;
            r_cross0   <= w_cross;
            if (w_cross) r_sign_neg <= ~r_sign_neg;
            r_cross1   <= r_cross0;
            r_prod_sin <= RESULT_WIDTH'(w_prod_sin);
            r_prod_cos <= RESULT_WIDTH'(w_prod_cos);
        end
    end

    // Stage2: per-half-period accumulation; a crossing sample opens the next half-period.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_acc_sin <= '0;
            r_acc_cos <= '0;
            r_len     <= '0;
            r_fin_sin <= '0;
            r_fin_cos <= '0;
            r_fin_len <= '0;
            r_hand    <= 1'b0;
        end else if (CE) begin
            r_hand <= 1'b0;
            if (r_vld_pipe[1]) begin
                if (r_cross1) begin
                    r_fin_sin <= r_acc_sin;
                    r_fin_cos <= r_acc_cos;
                    r_fin_len <= r_len;
                    r_hand    <= 1'b1;
                    r_acc_sin <= r_prod_sin;
                    r_acc_cos <= r_prod_cos;
                    r_len     <= PERIOD_WIDTH'(1);
                end else begin
                    r_acc_sin <= r_acc_sin + r_prod_sin;
                    r_acc_cos <= r_acc_cos + r_prod_cos;
                    if (r_len != '1) r_len <= r_len + 1'b1;
                end
            end
        end
    end

    // Stage3: sliding window over the last N half-periods via circular history.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                r_hist_sin[i] <= '0;
                r_hist_cos[i] <= '0;
            end
            r_win_sin  <= '0;
            r_win_cos  <= '0;
            r_wptr     <= '0;
            r_fill     <= '0;
            r_last_len <= '0;
            r_upd      <= 1'b0;
        end else if (CE) begin
            r_upd <= 1'b0;
            if (r_hand) begin
                r_hist_sin[r_wptr] <= r_fin_sin;
                r_hist_cos[r_wptr] <= r_fin_cos;
                r_win_sin  <= r_win_sin + r_fin_sin - r_hist_sin[r_wptr];
                r_win_cos  <= r_win_cos + r_fin_cos - r_hist_cos[r_wptr];
                r_wptr     <= r_wptr + 1'b1;
                r_last_len <= r_fin_len;
                if (r_fill != (PERIODS_LOG2+1)'(N)) r_fill <= r_fill + 1'b1;
                r_upd <= (r_fill >= (PERIODS_LOG2+1)'(N-1));
            end
        end
    end

    assign UPDATED_RESULT = r_upd;
    assign SIN_RESULT     = r_win_sin;
    assign COS_RESULT     = r_win_cos;
    assign LAST_LEN       = r_last_len;
endmodule
